// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default sizes, instruction field positions,
// opcode constants and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned INSTR_W_DEF  = 12;
    localparam int unsigned MAX_WAIT_DEF = 16;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPC_MSB = 11;
    localparam int unsigned OPC_LSB = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } fetchStateT;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: branch target (Imm or RegData) beats increment, increment wraps.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] regData,
    input  logic              loadPC,
    input  logic              selPC,
    input  logic              incPC,
    output logic [ADDR_W-1:0] pcNext_c
);

    always_comb begin
        pcNext_c = pc;
        if (loadPC) begin
            pcNext_c = selPC ? imm : regData;
        end else if (incPC) begin
            pcNext_c = pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, handshakes with instruction memory and
// presents one instruction per EXEC cycle to the controller.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned INSTR_W  = INSTR_W_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               CLK,
    input  logic               CLB,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [OPC_W-1:0]   Opcode,
    output logic [ADDR_W-1:0]  Imm,
    output logic               instr_valid,
    input  logic               LoadIR,
    input  logic               IncPC,
    input  logic               SelPC,
    input  logic               LoadPC,
    input  logic [ADDR_W-1:0]  RegData,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               fetch_err
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    fetchStateT         state;
    fetchStateT         stateNext;
    logic [ADDR_W-1:0]  pcQ;
    logic [ADDR_W-1:0]  pcNext;
    logic [ADDR_W-1:0]  pcTarget_c;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] irNext;
    logic [WAIT_W-1:0]  waitCnt;
    logic [WAIT_W-1:0]  waitCntNext;
    logic               errNext;
    logic               reqNext;
    logic               validNext;
    logic               haltedNext;
    logic [OPC_W-1:0]   opcodeNext;

    assign imem_addr = pcQ;
    assign pc        = pcQ;
    assign Imm       = ADDR_W'(ir[IMM_MSB:IMM_LSB]);

    fetch_unit_pc_next #(
        .ADDR_W (ADDR_W)
    ) uPcNext (
        .pc       (pcQ),
        .imm      (Imm),
        .regData  (RegData),
        .loadPC   (LoadPC),
        .selPC    (SelPC),
        .incPC    (IncPC),
        .pcNext_c (pcTarget_c)
    );

    // State, datapath and registered-output flops
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state       <= ST_FETCH;
            pcQ         <= '0;
            ir          <= '0;
            waitCnt     <= '0;
            fetch_err   <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            Opcode      <= OP_NOP;
        end else begin
            state       <= stateNext;
            pcQ         <= pcNext;
            ir          <= irNext;
            waitCnt     <= waitCntNext;
            fetch_err   <= errNext;
            imem_req    <= reqNext;
            instr_valid <= validNext;
            halted      <= haltedNext;
            Opcode      <= opcodeNext;
        end
    end

    // Next-state, datapath updates and the next value of every registered output
    always_comb begin
        stateNext   = state;
        pcNext      = pcQ;
        irNext      = ir;
        waitCntNext = waitCnt;
        errNext     = fetch_err;

        unique case (state)
            ST_FETCH: begin
                // The cycle right after reset has no request on the bus yet; only count once it is out.
                if (imem_req) begin
                    if (imem_ack) begin
                        irNext      = imem_rdata;
                        waitCntNext = '0;
                        stateNext   = ST_EXEC;
                    end else if (waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
                        errNext     = 1'b1;
                        waitCntNext = '0;
                        stateNext   = ST_HALT;
                    end else begin
                        waitCntNext = waitCnt + WAIT_W'(1);
                    end
                end
            end
            ST_EXEC: begin
                pcNext    = pcTarget_c;
                stateNext = LoadIR ? ST_FETCH : ST_HALT;
            end
            ST_HALT: begin
                stateNext = ST_HALT;
            end
            default: begin
                stateNext = ST_HALT;
            end
        endcase

        reqNext    = (stateNext == ST_FETCH);
        validNext  = (stateNext == ST_EXEC);
        haltedNext = (stateNext == ST_HALT);
        opcodeNext = (stateNext == ST_EXEC) ? irNext[OPC_MSB:OPC_LSB] : OP_NOP;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected fetch addresses and
// instructions, randomized memory latency and controller decisions.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        CLB;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [11:0] imem_rdata;
    logic [3:0]  Opcode;
    logic [7:0]  Imm;
    logic        instr_valid;
    logic        LoadIR;
    logic        IncPC;
    logic        SelPC;
    logic        LoadPC;
    logic [7:0]  RegData;
    logic [7:0]  pc;
    logic        halted;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  addrQ[$];
    logic [11:0] instrQ[$];
    int          pcModel = 0;

    fetch_unit dut (
        .CLK         (CLK),
        .CLB         (CLB),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Opcode      (Opcode),
        .Imm         (Imm),
        .instr_valid (instr_valid),
        .LoadIR      (LoadIR),
        .IncPC       (IncPC),
        .SelPC       (SelPC),
        .LoadPC      (LoadPC),
        .RegData     (RegData),
        .pc          (pc),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a fetch starts or an instruction is presented
    initial begin : monitor
        logic        reqPrev;
        logic [7:0]  curAddr;
        logic [11:0] e;
        reqPrev = 1'b0;
        curAddr = 8'h00;
        forever begin
            @(negedge CLK);
            if (!CLB) begin
                reqPrev = 1'b0;
            end else begin
                if (imem_req && !reqPrev) begin
                    if (addrQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_unexpected: request at 0x%0h, expected no fetch", imem_addr);
                    end else begin
                        curAddr = addrQ.pop_front();
                        chk("fetch_addr", int'(imem_addr), int'(curAddr));
                    end
                end else if (imem_req) begin
                    chk("addr_stable", int'(imem_addr), int'(curAddr));
                end
                if (instr_valid) begin
                    if (instrQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL valid_unexpected: instr_valid=1, expected 0");
                    end else begin
                        e = instrQ.pop_front();
                        chk("opcode", int'(Opcode), int'(e[11:8]));
                        chk("imm", int'(Imm), int'(e[7:0]));
                    end
                end else begin
                    chk("opcode_gated", int'(Opcode), 0);
                end
                reqPrev = imem_req;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic doReset();
        CLB = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("rst_req", int'(imem_req), 0);
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_opcode", int'(Opcode), 0);
        chk("rst_err", int'(fetch_err), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_imm", int'(Imm), 0);
        repeat (2) @(posedge CLK);
        #1;
        CLB = 1'b1;
        pcModel = 0;
        addrQ.push_back(8'h00);
    endtask

    // One fetch/exec pair: memory acks after d wait cycles, then the controller decides
    task automatic fetchOne(input int d, input logic [11:0] ins, input logic lir,
                            input logic inc, input logic lpc, input logic spc,
                            input logic [7:0] rd);
        int n = 0;
        while (!imem_req && n < 8) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("req_seen", int'(imem_req), 1);
        n = 0;
        repeat (d) begin
            imem_ack   = 1'b0;
            imem_rdata = 12'($urandom);
            @(posedge CLK);
            #1;
            if (imem_req) n++;
        end
        imem_ack   = 1'b1;
        imem_rdata = ins;
        instrQ.push_back(ins);
        @(posedge CLK);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = 12'($urandom);
        chk("req_held", n, d);
        chk("exec_valid", int'(instr_valid), 1);
        chk("exec_req_low", int'(imem_req), 0);
        LoadIR  = lir;
        IncPC   = inc;
        LoadPC  = lpc;
        SelPC   = spc;
        RegData = rd;
        if (lpc) pcModel = spc ? int'(ins[7:0]) : int'(rd);
        else if (inc) pcModel = (pcModel + 1) % 256;
        if (lir) addrQ.push_back(8'(pcModel));
        @(posedge CLK);
        #1;
        {LoadIR, IncPC, LoadPC, SelPC} = 4'($urandom);
        RegData = 8'($urandom);
        chk("pc", int'(pc), pcModel);
        chk("halted", int'(halted), int'(!lir));
        chk("valid_drop", int'(instr_valid), 0);
    endtask

    initial begin : stim
        int reqCnt;
        int haltLow;
        int pcBad;
        int n;
        CLB        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 12'h000;
        LoadIR     = 1'b0;
        IncPC      = 1'b0;
        SelPC      = 1'b0;
        LoadPC     = 1'b0;
        RegData    = 8'h00;
        doReset();

        // Zero-wait NOP stream: 0,1,2,3
        for (int i = 0; i < 4; i++) fetchOne(0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Branch to 0x05 then a 3-cycle-latency fetch there
        fetchOne(0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05);
        fetchOne(3, 12'h3A5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Branch targets: Imm, RegData, load beats increment
        fetchOne(1, 12'h140, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11);
        fetchOne(2, 12'h2AA, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7F);
        fetchOne(0, 12'h522, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);

        // Wrap at 0xFF and hold without IncPC
        fetchOne(0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
        fetchOne(0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        fetchOne(0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        fetchOne(1, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 40; i++) begin
            fetchOne(int'($urandom_range(0, 3)), 12'($urandom), 1'b1, 1'($urandom),
                     ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
        end

        // HALT instruction, then 100 cycles with stray acks
        fetchOne(0, 12'hF00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        reqCnt = 0;
        haltLow = 0;
        pcBad = 0;
        for (int i = 0; i < 100; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = 12'($urandom);
            @(posedge CLK);
            #1;
            if (imem_req) reqCnt++;
            if (!halted) haltLow++;
            if (int'(pc) != pcModel) pcBad++;
        end
        imem_ack = 1'b0;
        chk("halt_req_cycles", reqCnt, 0);
        chk("halt_low_cycles", haltLow, 0);
        chk("halt_pc_moves", pcBad, 0);
        chk("halt_no_err", int'(fetch_err), 0);

        // Memory timeout: 16 unacknowledged FETCH cycles
        doReset();
        @(posedge CLK);
        #1;
        chk("req_after_reset", int'(imem_req), 1);
        n = 0;
        while (!halted && n < 40) begin
            if (imem_req) n++;
            @(posedge CLK);
            #1;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_err", int'(fetch_err), 1);
        chk("timeout_halted", int'(halted), 1);
        chk("timeout_req", int'(imem_req), 0);
        chk("timeout_pc", int'(pc), 0);

        // Reset out of HALT, then reset again in the middle of a fetch
        doReset();
        repeat (3) @(posedge CLK);
        #1;
        chk("midfetch_req", int'(imem_req), 1);
        doReset();
        fetchOne(0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        fetchOne(1, 12'h1C3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        repeat (3) @(posedge CLK);
        #1;
        chk("addr_queue_drained", addrQ.size(), 0);
        chk("instr_queue_drained", instrQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
